intersect_sched: RTL and testbench

- Round-robin scheduler that shares one circle-intersection core among R requesters (e.g. per-anchor-pair trilateration lanes).
- Accepts packed circle operands (x, y, r) from each requester and issues one job at a time to the core.
- Waits for the core result and returns it to the owning requester with a valid/ready handshake.
- Sits between the localisation front end and the single intersection datapath instance.

---
 rtl/intersect_sched_if.sv | 28 ++
 rtl/intersect_sched.sv | 150 +++++++++++++++
 tb/tb_intersect_sched.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intersect_sched_if.sv
// Requester-side bus of the intersection scheduler: job requests in, results out.
// slave = scheduler side, master = requester side.
interface intersect_sched_if #(
   parameter int N = 8,
   parameter int R = 4
);
   localparam int OPW = 3*N+1;
   localparam int RW  = 14*N+34;

   logic [R-1:0]     req_valid;
   logic [R-1:0]     req_ready;
   logic [R*OPW-1:0] req_g;
   logic [R*OPW-1:0] req_e;
   logic [R-1:0]     resp_valid;
   logic [R-1:0]     resp_ready;
   logic [RW-1:0]    resp_data;
   logic             resp_err;

   modport slave (
      input  req_valid, req_g, req_e, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );

   modport master (
      output req_valid, req_g, req_e, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/intersect_sched.sv
// Round-robin scheduler sharing one circle-intersection core among R requesters.
// Optional WAIT-state timeout with core abort: define INTERSECT_TIMEOUT_EN.
module intersect_sched #(
   parameter int N   = 8,
   parameter int R   = 4,
   parameter int TMO = 1024
) (
   input  logic              clk,
   input  logic              rst,
   intersect_sched_if.slave  bus,
   output logic              core_start,
   output logic [3*N:0]      core_g,
   output logic [3*N:0]      core_e,
   input  logic              core_done,
   input  logic [14*N+33:0]  core_o,
   output logic              core_abort,
   output logic [15:0]       job_cnt
);
   localparam int OPW = 3*N+1;
   localparam int RW  = 14*N+34;
   localparam int IW  = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t          state_reg;
   logic [IW-1:0]   ptr_reg;
   logic [IW-1:0]   grant_reg;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   cand_idx;
   logic            grant_any;
   logic [R-1:0]    grant_onehot;
   logic            core_start_reg;
   logic [OPW-1:0]  core_g_reg;
   logic [OPW-1:0]  core_e_reg;
   logic [R-1:0]    resp_valid_reg;
   logic [RW-1:0]   resp_data_reg;
   logic [15:0]     job_cnt_reg;

   logic [OPW-1:0]  g_arr [R];
   logic [OPW-1:0]  e_arr [R];

   genvar gi;
   for (gi = 0; gi < R; gi++) begin : g_unpack
      assign g_arr[gi] = bus.req_g[gi*OPW +: OPW];
      assign e_arr[gi] = bus.req_e[gi*OPW +: OPW];
   end

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand_idx  = '0;
      for (int k = 1; k <= R; k++) begin
         cand_idx = IW'((int'(ptr_reg) + k) % R);
         if (!grant_any && bus.req_valid[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   assign grant_onehot  = R'(1) << grant_idx;
   assign bus.req_ready = (rst && state_reg == S_IDLE && grant_any) ? grant_onehot : '0;

`ifdef INTERSECT_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

   logic [15:0] tmo_cnt_reg;
   logic        resp_err_reg;
   logic        tmo_hit;

   // A core_done landing on the last WAIT cycle beats the timeout.
   assign tmo_hit      = (state_reg == S_WAIT) && (tmo_cnt_reg == TMO_LAST) && !core_done;
   assign core_abort   = tmo_hit;
   assign bus.resp_err = resp_err_reg;
`else
   assign core_abort   = 1'b0;
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= S_IDLE;
         ptr_reg        <= IW'(R - 1);
         grant_reg      <= '0;
         core_start_reg <= 1'b0;
         core_g_reg     <= '0;
         core_e_reg     <= '0;
         resp_valid_reg <= '0;
         resp_data_reg  <= '0;
         job_cnt_reg    <= '0;
`ifdef INTERSECT_TIMEOUT_EN
         tmo_cnt_reg    <= '0;
         resp_err_reg   <= 1'b0;
`endif
      end else begin
         core_start_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (grant_any) begin
                  core_g_reg     <= g_arr[grant_idx];
                  core_e_reg     <= e_arr[grant_idx];
                  grant_reg      <= grant_idx;
                  ptr_reg        <= grant_idx;
                  core_start_reg <= 1'b1;
                  state_reg      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state_reg <= S_WAIT;
`ifdef INTERSECT_TIMEOUT_EN
               tmo_cnt_reg <= '0;
`endif
            end
            S_WAIT: begin
               if (core_done) begin
                  resp_data_reg  <= core_o;
                  resp_valid_reg <= R'(1) << grant_reg;
                  state_reg      <= S_RESP;
`ifdef INTERSECT_TIMEOUT_EN
                  resp_err_reg   <= 1'b0;
               end else if (tmo_hit) begin
                  resp_data_reg  <= '0;
                  resp_err_reg   <= 1'b1;
                  resp_valid_reg <= R'(1) << grant_reg;
                  state_reg      <= S_RESP;
               end else begin
                  tmo_cnt_reg    <= tmo_cnt_reg + 16'd1;
`endif
               end
            end
            S_RESP: begin
               if (bus.resp_ready[grant_reg]) begin
                  job_cnt_reg    <= job_cnt_reg + 16'd1;
                  resp_valid_reg <= '0;
                  state_reg      <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign core_start     = core_start_reg;
   assign core_g         = core_g_reg;
   assign core_e         = core_e_reg;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_data  = resp_data_reg;
   assign job_cnt        = job_cnt_reg;
endmodule

// File: tb/tb_intersect_sched.sv
// Directed bench for intersect_sched: reset, grant order, back-pressure, reset mid-job, timeout.
module tb_intersect_sched;
   localparam int N   = 8;
   localparam int R   = 4;
   localparam int TMO = 16;
   localparam int OPW = 3*N+1;
   localparam int RW  = 14*N+34;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            core_start;
   logic [OPW-1:0]  core_g;
   logic [OPW-1:0]  core_e;
   logic            core_done;
   logic [RW-1:0]   core_o;
   logic            core_abort;
   logic [15:0]     job_cnt;
   int              checks = 0;
   int              errors = 0;

   intersect_sched_if #(.N(N), .R(R)) bus ();

   intersect_sched #(.N(N), .R(R), .TMO(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .core_start (core_start),
      .core_g     (core_g),
      .core_e     (core_e),
      .core_done  (core_done),
      .core_o     (core_o),
      .core_abort (core_abort),
      .job_cnt    (job_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [OPW-1:0] gval(input int i);
      return 25'h1234560 + 25'(i) * 25'h0010001;
   endfunction

   function automatic logic [OPW-1:0] eval_op(input int i);
      return 25'h0FEDCB0 ^ 25'(i);
   endfunction

   function automatic logic [RW-1:0] mk_res(input int k);
      return {18'(k + 1), 64'hDEADBEEF01234567, 64'h89ABCDEF5555AAAA ^ 64'(k)};
   endfunction

   task automatic apply_reset();
      rst = 1'b0;
      bus.req_valid  = '0;
      bus.resp_ready = '1;
      core_done = 1'b0;
      core_o    = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // One full job with resp_ready held high; returns what the DUT showed.
   task automatic do_job(input logic [3:0] valid, input int lat, input logic [RW-1:0] res,
                         output logic [3:0] gnt, output logic start1, output int starts,
                         output logic [3:0] rv, output logic [RW-1:0] data, output logic err);
      starts = 0;
      bus.req_valid = valid;
      #1 gnt = bus.req_ready;
      @(posedge clk); #1;
      bus.req_valid = '0;
      start1 = core_start;
      starts += int'(core_start);
      for (int c = 0; c < lat; c++) begin
         @(posedge clk); #1;
         starts += int'(core_start);
      end
      core_done = 1'b1;
      core_o    = res;
      @(posedge clk); #1;
      core_done = 1'b0;
      rv   = bus.resp_valid;
      data = bus.resp_data;
      err  = bus.resp_err;
      starts += int'(core_start);
      @(posedge clk); #1;
      $display("job req_valid=%b grant=%b resp_valid=%b err=%b data=%h", valid, gnt, rv, err, data);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req_valid  = 4'b0001;
      bus.resp_ready = '1;
      core_done = 1'b0;
      core_o    = '0;
      @(posedge clk); #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
      checks++; if (bus.resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0000", bus.resp_valid); end
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b expected 0", core_start); end
      checks++; if (job_cnt !== 16'd0) begin errors++; $display("FAIL reset_job_cnt: got %0d expected 0", job_cnt); end
      checks++; if (core_g !== '0) begin errors++; $display("FAIL reset_core_g: got %h expected 0", core_g); end
      checks++; if (bus.resp_data !== '0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
      bus.req_valid = '0;
      @(posedge clk); #1 rst = 1'b1;
      #1;
      checks++; if (core_abort !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_abort_err: got %b%b expected 00", core_abort, bus.resp_err); end
      $display("reset done");
   endtask

   task automatic test_single();
      logic [3:0] gnt, rv;
      logic s1, err;
      int starts;
      logic [RW-1:0] data;
      apply_reset();
      do_job(4'b0001, 10, mk_res(0), gnt, s1, starts, rv, data, err);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", gnt); end
      checks++; if (s1 !== 1'b1) begin errors++; $display("FAIL single_start_cycle1: got %b expected 1", s1); end
      checks++; if (starts != 1) begin errors++; $display("FAIL single_start_count: got %0d expected 1", starts); end
      checks++; if (rv !== 4'b0001) begin errors++; $display("FAIL single_resp_valid: got %b expected 0001", rv); end
      checks++; if (data !== mk_res(0)) begin errors++; $display("FAIL single_resp_data: got %h expected %h", data, mk_res(0)); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_resp_err: got %b expected 0", err); end
      checks++; if (job_cnt !== 16'd1) begin errors++; $display("FAIL single_job_cnt: got %0d expected 1", job_cnt); end
      checks++; if (core_g !== gval(0) || core_e !== eval_op(0)) begin errors++; $display("FAIL single_operands: got %h/%h expected %h/%h", core_g, core_e, gval(0), eval_op(0)); end
   endtask

   task automatic test_round_robin();
      logic [3:0] gnt, rv, exp;
      logic s1, err;
      int starts;
      logic [RW-1:0] data;
      int sparse_order[3] = '{1, 3, 1};
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         exp = 4'b0001 << (k % 4);
         do_job(4'b1111, 2, mk_res(k + 1), gnt, s1, starts, rv, data, err);
         checks++; if (gnt !== exp || rv !== exp) begin errors++; $display("FAIL rr_grant_%0d: got %b/%b expected %b", k, gnt, rv, exp); end
         checks++; if (data !== mk_res(k + 1)) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", k, data, mk_res(k + 1)); end
         checks++; if (core_g !== gval(k % 4)) begin errors++; $display("FAIL rr_core_g_%0d: got %h expected %h", k, core_g, gval(k % 4)); end
      end
      checks++; if (job_cnt !== 16'd8) begin errors++; $display("FAIL rr_job_cnt: got %0d expected 8", job_cnt); end
      for (int k = 0; k < 3; k++) begin
         exp = 4'b0001 << sparse_order[k];
         do_job(4'b1010, 1, mk_res(k + 10), gnt, s1, starts, rv, data, err);
         checks++; if (gnt !== exp || rv !== exp) begin errors++; $display("FAIL rr_sparse_%0d: got %b/%b expected %b", k, gnt, rv, exp); end
      end
      checks++; if (job_cnt !== 16'd11) begin errors++; $display("FAIL rr_sparse_job_cnt: got %0d expected 11", job_cnt); end
   endtask

   task automatic test_back_pressure();
      int bad_valid, bad_data, bad_rr, bad_start;
      apply_reset();
      bus.resp_ready = 4'b0000;
      bus.req_valid  = 4'b0010;
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = 4'b1111;
      #1;
      checks++; if (core_start !== 1'b1 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_issue: start=%b ready=%b expected 1/0000", core_start, bus.req_ready); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      core_done = 1'b1;
      core_o    = mk_res(20);
      @(posedge clk); #1;
      core_done = 1'b0;
      core_o    = '0;
      bus.resp_ready = 4'b1101;
      bad_valid = 0; bad_data = 0; bad_rr = 0; bad_start = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus.resp_valid !== 4'b0010) bad_valid++;
         if (bus.resp_data !== mk_res(20)) bad_data++;
         if (bus.req_ready !== 4'b0000) bad_rr++;
         if (core_start !== 1'b0) bad_start++;
         @(posedge clk); #1;
      end
      checks++; if (bad_valid != 0) begin errors++; $display("FAIL bp_resp_valid_stable: got %0d bad cycles expected 0", bad_valid); end
      checks++; if (bad_data != 0) begin errors++; $display("FAIL bp_resp_data_stable: got %0d bad cycles expected 0", bad_data); end
      checks++; if (bad_rr != 0) begin errors++; $display("FAIL bp_no_req_ready: got %0d bad cycles expected 0", bad_rr); end
      checks++; if (bad_start != 0) begin errors++; $display("FAIL bp_no_core_start: got %0d bad cycles expected 0", bad_start); end
      checks++; if (job_cnt !== 16'd0) begin errors++; $display("FAIL bp_job_cnt_held: got %0d expected 0", job_cnt); end
      bus.resp_ready = 4'b0010;
      @(posedge clk); #1;
      bus.resp_ready = '1;
      #1;
      checks++; if (job_cnt !== 16'd1 || bus.resp_valid !== 4'b0000) begin errors++; $display("FAIL bp_accept: job_cnt=%0d resp_valid=%b expected 1/0000", job_cnt, bus.resp_valid); end
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got %b expected 0100", bus.req_ready); end
      bus.req_valid = '0;
      @(posedge clk); #1;
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL bp_withdrawn_req: core_start=%b expected 0", core_start); end
      $display("job back_pressure resp_data=%h job_cnt=%0d", mk_res(20), job_cnt);
   endtask

   task automatic test_reset_mid_wait();
      logic [3:0] gnt, rv;
      logic s1, err;
      int starts;
      logic [RW-1:0] data;
      apply_reset();
      bus.req_valid = 4'b0001;
      @(posedge clk); #1;
      bus.req_valid = '0;
      core_done = 1'b1;
      core_o    = mk_res(30);
      @(posedge clk); #1;
      core_done = 1'b0;
      #1;
      checks++; if (bus.resp_valid !== 4'b0000) begin errors++; $display("FAIL mid_done_in_issue: resp_valid=%b expected 0000", bus.resp_valid); end
      @(posedge clk); #1;
      checks++; if (core_g !== gval(0)) begin errors++; $display("FAIL mid_latched_g: got %h expected %h", core_g, gval(0)); end
      rst = 1'b0;
      #1;
      checks++; if (core_g !== '0 || core_e !== '0) begin errors++; $display("FAIL mid_async_operands: got %h/%h expected 0/0", core_g, core_e); end
      checks++; if (bus.resp_valid !== 4'b0000 || core_start !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_async_ctrl: valid=%b start=%b ready=%b expected 0", bus.resp_valid, core_start, bus.req_ready); end
      @(posedge clk); #1 rst = 1'b1;
      core_done = 1'b1;
      core_o    = mk_res(31);
      @(posedge clk); #1;
      core_done = 1'b0;
      #1;
      checks++; if (bus.resp_valid !== 4'b0000) begin errors++; $display("FAIL mid_stale_done: resp_valid=%b expected 0000", bus.resp_valid); end
      do_job(4'b0100, 3, mk_res(32), gnt, s1, starts, rv, data, err);
      checks++; if (gnt !== 4'b0100 || rv !== 4'b0100) begin errors++; $display("FAIL mid_regrant: got %b/%b expected 0100", gnt, rv); end
      checks++; if (data !== mk_res(32)) begin errors++; $display("FAIL mid_data: got %h expected %h", data, mk_res(32)); end
      checks++; if (job_cnt !== 16'd1) begin errors++; $display("FAIL mid_job_cnt: got %0d expected 1", job_cnt); end
   endtask

`ifdef INTERSECT_TIMEOUT_EN
   task automatic test_timeout();
      logic [3:0] gnt, rv;
      logic s1, err;
      int starts, early;
      logic [RW-1:0] data;
      apply_reset();
      do_job(4'b0001, 2, mk_res(40), gnt, s1, starts, rv, data, err);
      bus.req_valid = 4'b0001;
      @(posedge clk); #1;
      bus.req_valid = '0;
      early = 0;
      for (int w = 1; w <= 15; w++) begin
         @(posedge clk); #2;
         if (core_abort !== 1'b0 || bus.resp_valid !== 4'b0000) early++;
      end
      @(posedge clk); #2;
      checks++; if (early != 0) begin errors++; $display("FAIL tmo_early: got %0d bad cycles expected 0", early); end
      checks++; if (core_abort !== 1'b1) begin errors++; $display("FAIL tmo_abort_cycle16: got %b expected 1", core_abort); end
      @(posedge clk); #1;
      checks++; if (core_abort !== 1'b0) begin errors++; $display("FAIL tmo_abort_pulse: got %b expected 0", core_abort); end
      checks++; if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b1) begin errors++; $display("FAIL tmo_resp: valid=%b err=%b expected 0001/1", bus.resp_valid, bus.resp_err); end
      checks++; if (bus.resp_data !== '0) begin errors++; $display("FAIL tmo_resp_data: got %h expected 0", bus.resp_data); end
      @(posedge clk); #1;
      checks++; if (job_cnt !== 16'd2) begin errors++; $display("FAIL tmo_job_cnt: got %0d expected 2", job_cnt); end
      $display("job timeout grant=0001 err=1 job_cnt=%0d", job_cnt);
   endtask

   task automatic test_timeout_tie();
      apply_reset();
      bus.req_valid = 4'b0001;
      @(posedge clk); #1;
      bus.req_valid = '0;
      for (int w = 1; w <= 15; w++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      core_done = 1'b1;
      core_o    = mk_res(41);
      #1;
      checks++; if (core_abort !== 1'b0) begin errors++; $display("FAIL tie_no_abort: got %b expected 0", core_abort); end
      @(posedge clk); #1;
      core_done = 1'b0;
      checks++; if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL tie_resp: valid=%b err=%b expected 0001/0", bus.resp_valid, bus.resp_err); end
      checks++; if (bus.resp_data !== mk_res(41)) begin errors++; $display("FAIL tie_data: got %h expected %h", bus.resp_data, mk_res(41)); end
      @(posedge clk); #1;
      $display("job timeout_tie grant=0001 err=0 job_cnt=%0d", job_cnt);
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      apply_reset();
      bus.req_valid = 4'b0001;
      @(posedge clk); #1;
      bus.req_valid = '0;
      bad = 0;
      for (int w = 0; w < 40; w++) begin
         @(posedge clk); #2;
         if (core_abort !== 1'b0 || bus.resp_valid !== 4'b0000) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL notmo_wait_unbounded: got %0d bad cycles expected 0", bad); end
      core_done = 1'b1;
      core_o    = mk_res(50);
      @(posedge clk); #1;
      core_done = 1'b0;
      checks++; if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL notmo_resp: valid=%b err=%b expected 0001/0", bus.resp_valid, bus.resp_err); end
      checks++; if (bus.resp_data !== mk_res(50)) begin errors++; $display("FAIL notmo_data: got %h expected %h", bus.resp_data, mk_res(50)); end
      @(posedge clk); #1;
      checks++; if (job_cnt !== 16'd1) begin errors++; $display("FAIL notmo_job_cnt: got %0d expected 1", job_cnt); end
      $display("job long_wait grant=0001 err=0 job_cnt=%0d", job_cnt);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = '0;
      bus.resp_ready = '1;
      core_done = 1'b0;
      core_o    = '0;
      for (int i = 0; i < R; i++) begin
         bus.req_g[i*OPW +: OPW] = gval(i);
         bus.req_e[i*OPW +: OPW] = eval_op(i);
      end
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_reset_mid_wait();
`ifdef INTERSECT_TIMEOUT_EN
      test_timeout();
      test_timeout_tie();
`else
      test_no_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
